eth_pad_shifter: RTL



---
 rtl/eth_pad_shifter_pkg.sv | 28 ++
 rtl/eth_pad_shifter_if.sv | 15 +
 rtl/eth_pad_shifter.sv | 117 +++++++++++
 3 files changed

// File: rtl/eth_pad_shifter_pkg.sv
// Shared definitions for eth_pad_shifter: FSM encoding and byte helpers.
//   bytes_valid : byte count of a last word from its tuser field (0 means full)
//   byte_mask   : mask with the low n bytes set, sized for the widest bus
package eth_pad_shifter_pkg;

  localparam int unsigned MAX_DWIDTH = 512;
  localparam int unsigned MAX_BYTES  = MAX_DWIDTH / 8;

  localparam logic [1:0] ST_FIRST = 2'd0;
  localparam logic [1:0] ST_BODY  = 2'd1;
  localparam logic [1:0] ST_EXTRA = 2'd2;

  // tuser==0 encodes a completely filled word
  function automatic int unsigned bytes_valid(input int unsigned tuser, input int unsigned b);
    return (tuser == 0) ? b : tuser;
  endfunction

  // Low n bytes (capped at b) set; callers truncate to their bus width
  function automatic logic [MAX_DWIDTH-1:0] byte_mask(input int unsigned n, input int unsigned b);
    logic [MAX_DWIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < n && i < b) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/eth_pad_shifter_if.sv
// AXI-Stream bundle used on both sides of eth_pad_shifter.
//   tdata/tuser/tlast/tvalid flow master->slave, tready flows slave->master.
interface eth_pad_shifter_if #(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned UWIDTH = $clog2(DWIDTH / 8)
);
  logic [DWIDTH-1:0] tdata;
  logic [UWIDTH-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/eth_pad_shifter.sv
// Prepends PAD_BYTES zero bytes to every AXI-Stream frame so the payload after
// the Ethernet header lands word-aligned.
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous flush, same effect as reset, wins over handshakes
//   s_axis     : input stream (slave side)
//   m_axis     : output stream (master side), one registered stage
module eth_pad_shifter
  import eth_pad_shifter_pkg::*;
#(
  parameter int unsigned DWIDTH    = 64,
  parameter int unsigned PAD_BYTES = 6,
  parameter int unsigned UWIDTH    = $clog2(DWIDTH / 8)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  eth_pad_shifter_if.slave    s_axis,
  eth_pad_shifter_if.master   m_axis
);

  localparam int unsigned B      = DWIDTH / 8;
  localparam int unsigned P      = PAD_BYTES;
  localparam int unsigned SHIFT  = 8 * P;
  localparam int unsigned CSHIFT = 8 * (B - P);

  logic [1:0]        state_q, state_d;
  logic [DWIDTH-1:0] carry_q, carry_d;   // only the low P bytes are ever non-zero
  logic [UWIDTH-1:0] rem_q, rem_d;
  logic [DWIDTH-1:0] tdata_q, tdata_d;
  logic [UWIDTH-1:0] tuser_q, tuser_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;

  logic              adv_c;
  logic              ready_c;
  int unsigned       n_c;
  logic [DWIDTH-1:0] in_masked_c;

  // Next-state, shift/carry and output-register computation
  always_comb begin
    state_d  = state_q;
    carry_d  = carry_q;
    rem_d    = rem_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;

    adv_c   = !tvalid_q || m_axis.tready;
    // Gated by reset/clear so nothing is handed over during a flush
    ready_c = adv_c && (state_q != ST_EXTRA) && !reset && !clear;

    n_c         = s_axis.tlast ? bytes_valid(32'(s_axis.tuser), B) : B;
    in_masked_c = s_axis.tdata & DWIDTH'(byte_mask(n_c, B));

    if (state_q == ST_EXTRA) begin
      // Overflow word: the leftover carry bytes of the last input word
      if (adv_c) begin
        tdata_d  = carry_q & DWIDTH'(byte_mask(32'(rem_q), B));
        tuser_d  = rem_q;
        tlast_d  = 1'b1;
        tvalid_d = 1'b1;
        state_d  = ST_FIRST;
      end
    end else if (s_axis.tvalid && ready_c) begin
      tdata_d  = (in_masked_c << SHIFT) | ((state_q == ST_BODY) ? carry_q : '0);
      carry_d  = (P == 0) ? '0 : (in_masked_c >> CSHIFT);
      tvalid_d = 1'b1;
      if (s_axis.tlast) begin
        if (n_c + P <= B) begin
          tlast_d = 1'b1;
          tuser_d = UWIDTH'((n_c + P) % B);
          state_d = ST_FIRST;
        end else begin
          tlast_d = 1'b0;
          tuser_d = '0;
          rem_d   = UWIDTH'(n_c + P - B);
          state_d = ST_EXTRA;
        end
      end else begin
        tlast_d = 1'b0;
        tuser_d = '0;
        state_d = ST_BODY;
      end
    end else if (adv_c) begin
      tvalid_d = 1'b0;
    end
  end

  // State and output registers; clear behaves exactly like reset
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q  <= ST_FIRST;
      carry_q  <= '0;
      rem_q    <= '0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      carry_q  <= carry_d;
      rem_q    <= rem_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign s_axis.tready = ready_c;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tvalid = tvalid_q;

endmodule
